// File: rtl/risc16_mem_arbiter_pkg.sv
// risc16_mem_pkg: shared types and address-map constants for the RISC16 memory arbiter.
package risc16_mem_pkg;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int MW = AW - 1;
  localparam logic [AW-1:0] MMIO_BASE = 16'h0200;
  localparam logic [1:0] LED01_OFS = 2'h0;
  localparam logic [1:0] LED2_OFS = 2'h2;
  typedef enum logic [1:0] {IDLE, INST2, REL, HOST_R} state_t;
  function automatic logic is_mmio(input logic [AW-1:0] a);
    return a[AW-1:2] == MMIO_BASE[AW-1:2];
  endfunction
endpackage

// File: rtl/risc16_mem_arbiter_if.sv
// risc16_mem_arbiter_if: CPU fetch/data port and host word port bundled between requesters and the arbiter.
interface risc16_mem_arbiter_if;
  logic [15:0] iaddr, idin, daddr, ddout, ddin, h_addr, h_wdata, h_rdata;
  logic ioe, doe, dwe0, dwe1, stall, h_req, h_we, h_gnt, h_rvalid;
  modport master (
    output iaddr, ioe, daddr, ddout, doe, dwe0, dwe1, h_req, h_we, h_addr, h_wdata,
    input  idin, ddin, stall, h_gnt, h_rvalid, h_rdata
  );
  modport slave (
    input  iaddr, ioe, daddr, ddout, doe, dwe0, dwe1, h_req, h_we, h_addr, h_wdata,
    output idin, ddin, stall, h_gnt, h_rvalid, h_rdata
  );
endinterface

// File: rtl/risc16_mem_arbiter_led_mmio.sv
// risc16_led_mmio: three 8-bit LED registers behind the MMIO window with byte-lane write decode and read mux.
module risc16_led_mmio
  import risc16_mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [1:0]  be,
  input  logic        ofs,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic [23:0] led
);
  logic sel2;
  assign sel2 = ofs == LED2_OFS[1];
  // the high LED register only has an odd-byte lane; even-byte writes to it are dropped
  always_ff @(posedge clk)
    if (rst) led <= '0;
    else if (we) begin
      if (!sel2 && be[1]) led[15:8] <= wdata[15:8];
      if (!sel2 && be[0]) led[7:0] <= wdata[7:0];
      if (sel2 && be[0]) led[23:16] <= wdata[7:0];
    end
  assign rdata = sel2 ? {8'h00, led[23:16]} : led[15:0];
endmodule

// File: rtl/risc16_mem_arbiter.sv
// risc16_mem_arbiter: shares one synchronous SRAM port between CPU fetch, CPU data and a host loader,
// alternating host and CPU slots, and decodes the LED MMIO window.
module risc16_mem_arbiter
  import risc16_mem_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  risc16_mem_arbiter_if.slave bus,
  output logic                m_en,
  output logic [1:0]          m_we,
  output logic [MW-1:0]       m_addr,
  output logic [DW-1:0]       m_wdata,
  input  logic [DW-1:0]       m_rdata,
  output logic [23:0]         led
);
  state_t state, nxt;
  logic act, cpu_req, mmio, dacc, host_go, host_mem, cpu_go, iss_d, iss_i, rel;
  logic host_turn, rd_i, rd_d, rd_m, h_rd, unused;
  logic [DW-1:0] idin_q, ddin_q, mm_rdata;
  assign act = !rst;
  assign cpu_req = bus.ioe | bus.doe | bus.dwe0 | bus.dwe1;
  assign mmio = is_mmio(bus.daddr);
  assign dacc = (bus.doe | bus.dwe0 | bus.dwe1) & !mmio;
  assign host_go = act & (state == IDLE) & bus.h_req & (host_turn | !cpu_req);
  assign host_mem = host_go & !is_mmio(bus.h_addr);
  assign cpu_go = act & (state == IDLE) & cpu_req & !host_go;
  assign iss_d = cpu_go & dacc;
  assign iss_i = (cpu_go & !dacc & bus.ioe) | (act & (state == INST2));
  assign rel = act & (state == REL);
  assign unused = ^{bus.iaddr[0], bus.daddr[0], bus.h_addr[0]};
  risc16_led_mmio u_led (
    .clk,
    .rst,
    .we(cpu_go & mmio),
    .be({bus.dwe0, bus.dwe1}),
    .ofs(bus.daddr[1]),
    .wdata(bus.ddout),
    .rdata(mm_rdata),
    .led
  );
  always_ff @(posedge clk) state <= rst ? IDLE : nxt;
  always_comb
    nxt = (state == IDLE) ? (host_go ? HOST_R : cpu_go ? ((dacc & bus.ioe) ? INST2 : REL) : IDLE)
        : (state == INST2) ? REL : IDLE;
  always_comb begin
    m_en = host_mem | iss_d | iss_i;
    m_we = host_mem ? {2{bus.h_we}} : iss_d ? {bus.dwe0, bus.dwe1} : 2'b00;
    m_addr = host_mem ? bus.h_addr[15:1] : iss_d ? bus.daddr[15:1] : iss_i ? bus.iaddr[15:1] : '0;
    m_wdata = host_mem ? bus.h_wdata : iss_d ? bus.ddout : '0;
  end
  assign bus.stall = act & cpu_req & (state != REL);
  assign bus.h_gnt = host_go;
  assign bus.h_rvalid = act & (state == HOST_R) & h_rd;
  assign bus.h_rdata = bus.h_rvalid ? m_rdata : '0;
  assign bus.idin = (rel & rd_i) ? m_rdata : idin_q;
  assign bus.ddin = (rel & rd_d) ? m_rdata : (rel & rd_m) ? mm_rdata : ddin_q;
  // rd_* remember what was issued last cycle so the release cycle can route m_rdata
  always_ff @(posedge clk)
    if (rst) begin
      host_turn <= 1'b0;
      rd_i <= 1'b0;
      rd_d <= 1'b0;
      rd_m <= 1'b0;
      h_rd <= 1'b0;
      idin_q <= '0;
      ddin_q <= '0;
    end else begin
      host_turn <= (state == REL) | (host_turn & (state != HOST_R));
      rd_i <= iss_i;
      rd_d <= iss_d & bus.doe;
      rd_m <= cpu_go & mmio & bus.doe;
      h_rd <= host_go & !bus.h_we;
      idin_q <= bus.idin;
      ddin_q <= (state == INST2 && rd_d) ? m_rdata : bus.ddin;
    end
endmodule

// File: tb/tb_risc16_mem_arbiter.sv
// tb_risc16_mem_arbiter: directed and randomized CPU/host traffic, every cycle checked against a
// transaction-level model of slots, latencies, memory contents and LED registers.
module tb_risc16_mem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic m_en;
  logic [1:0] m_we;
  logic [14:0] m_addr;
  logic [15:0] m_wdata, m_rdata;
  logic [23:0] led;
  risc16_mem_arbiter_if bus();
  risc16_mem_arbiter dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .m_en(m_en),
    .m_we(m_we),
    .m_addr(m_addr),
    .m_wdata(m_wdata),
    .m_rdata(m_rdata),
    .led(led)
  );
  always #5 clk = ~clk;

  logic [15:0] sram [0:32767];
  logic [15:0] ref_mem [0:32767];
  always @(posedge clk)
    if (m_en) begin
      m_rdata <= sram[m_addr];
      if (m_we[1]) sram[m_addr][15:8] <= m_wdata[15:8];
      if (m_we[0]) sram[m_addr][7:0] <= m_wdata[7:0];
    end

  typedef struct {
    bit stall, gnt, rv, en, rs, chk;
    logic [1:0] we;
    logic [14:0] ma;
    logic [15:0] wd, hr, id, dd;
    logic [23:0] led;
  } exp_t;
  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] id_m, dd_m;
  logic [23:0] led_m;
  bit hturn, hpend;

  task automatic chk(string nm, logic [31:0] got, logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at t=%0t", nm, got, want, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("stall", bus.stall, e.stall);
      chk("h_gnt", bus.h_gnt, e.gnt);
      chk("h_rvalid", bus.h_rvalid, e.rv);
      chk("m_en", m_en, e.en);
      chk("m_we", m_we, e.we);
      if (e.en) chk("m_addr", m_addr, e.ma);
      if (e.we != 2'b00) chk("m_wdata", m_wdata, e.wd);
      if (e.rv || e.rs) chk("h_rdata", bus.h_rdata, e.hr);
      if (e.chk) begin
        chk("idin", bus.idin, e.id);
        chk("ddin", bus.ddin, e.dd);
        chk("led", led, e.led);
      end
    end
  end

  function automatic exp_t base();
    exp_t e;
    e = '{default: '0};
    e.chk = 1'b1;
    e.id = id_m;
    e.dd = dd_m;
    e.led = led_m;
    return e;
  endfunction

  task automatic cycle(exp_t e);
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic setmem(logic [14:0] a, logic [15:0] v);
    sram[a] = v;
    ref_mem[a] = v;
  endtask

  task automatic raise_host(bit we, logic [15:0] a, logic [15:0] wd);
    bus.h_req = 1'b1;
    bus.h_we = we;
    bus.h_addr = a;
    bus.h_wdata = wd;
    hpend = 1'b1;
  endtask

  // host slot: grant+issue cycle, then read-return cycle; the host gives up its turn afterwards
  task automatic host_slot(bit with_cpu);
    exp_t e;
    logic [14:0] a;
    logic [15:0] hr;
    a = bus.h_addr[15:1];
    hr = ref_mem[a];
    e = base();
    e.stall = with_cpu;
    e.gnt = 1'b1;
    e.en = 1'b1;
    e.we = {2{bus.h_we}};
    e.ma = a;
    e.wd = bus.h_wdata;
    if (bus.h_we) ref_mem[a] = bus.h_wdata;
    cycle(e);
    bus.h_req = 1'b0;
    e = base();
    e.stall = with_cpu;
    e.rv = !bus.h_we;
    e.hr = hr;
    cycle(e);
    hpend = 1'b0;
    hturn = 1'b0;
  endtask

  // one CPU instruction: optional host slot, issue, optional second fetch cycle, release
  task automatic instr(bit ioe, logic [15:0] ia, bit doe, bit w0, bit w1, logic [15:0] da, logic [15:0] wd);
    exp_t e;
    bit mm, dacc;
    logic [15:0] rd;
    bus.ioe = ioe;
    bus.iaddr = ia;
    bus.doe = doe;
    bus.dwe0 = w0;
    bus.dwe1 = w1;
    bus.daddr = da;
    bus.ddout = wd;
    mm = (da >= 16'h0200) && (da <= 16'h0203);
    dacc = (doe | w0 | w1) & !mm;
    if (hpend && hturn) host_slot(1'b1);
    rd = ref_mem[da[15:1]];
    e = base();
    e.stall = 1'b1;
    e.en = dacc | ioe;
    e.we = dacc ? {w0, w1} : 2'b00;
    e.ma = dacc ? da[15:1] : ia[15:1];
    e.wd = wd;
    if (dacc && w0) ref_mem[da[15:1]][15:8] = wd[15:8];
    if (dacc && w1) ref_mem[da[15:1]][7:0] = wd[7:0];
    if (mm && !da[1] && w0) led_m[15:8] = wd[15:8];
    if (mm && !da[1] && w1) led_m[7:0] = wd[7:0];
    if (mm && da[1] && w1) led_m[23:16] = wd[7:0];
    cycle(e);
    if (dacc && ioe) begin
      e = base();
      e.stall = 1'b1;
      e.en = 1'b1;
      e.ma = ia[15:1];
      cycle(e);
    end
    if (ioe) id_m = ref_mem[ia[15:1]];
    if (doe) dd_m = mm ? (da[1] ? {8'h00, led_m[23:16]} : led_m[15:0]) : rd;
    cycle(base());
    hturn = 1'b1;
  endtask

  task automatic gap();
    bus.ioe = 1'b0;
    bus.doe = 1'b0;
    bus.dwe0 = 1'b0;
    bus.dwe1 = 1'b0;
    if (hpend) host_slot(1'b0);
    else cycle(base());
  endtask

  initial begin
    exp_t e;
    for (int i = 0; i < 32768; i++) setmem(15'(i), 16'(i * 40503 + 17));
    {bus.ioe, bus.doe, bus.dwe0, bus.dwe1, bus.h_req, bus.h_we} = '0;
    {bus.iaddr, bus.daddr, bus.ddout, bus.h_addr, bus.h_wdata} = '0;
    id_m = '0;
    dd_m = '0;
    led_m = '0;
    hturn = 1'b0;
    hpend = 1'b0;
    @(posedge clk);
    #1;
    e = base();
    e.rs = 1'b1;
    cycle(e);
    rst = 1'b0;

    setmem(15'h0008, 16'h1234);
    instr(1'b1, 16'h0010, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    chk("fetch_idin", bus.idin, 16'h1234);
    setmem(15'h6000, 16'hBEEF);
    instr(1'b1, 16'h0012, 1'b1, 1'b0, 1'b0, 16'hC000, 16'h0000);
    chk("load_ddin", bus.ddin, 16'hBEEF);
    chk("load_idin", bus.idin, ref_mem[9]);
    instr(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'hC001, 16'h00AA);
    chk("byte_store", sram[15'h6000], 16'hBEAA);
    instr(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0200, 16'h1234);
    instr(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0202, 16'h0056);
    chk("led_write", led, 24'h561234);
    instr(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0202, 16'hFF00);
    chk("led2_even_ignored", led, 24'h561234);
    instr(1'b1, 16'h0004, 1'b1, 1'b0, 1'b0, 16'h0202, 16'h0000);
    chk("mmio_rd_hi", bus.ddin, 16'h0056);
    instr(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0201, 16'h0000);
    chk("mmio_rd_lo", bus.ddin, 16'h1234);
    chk("mmio_no_sram", sram[15'h0100], 16'(32'h100 * 40503 + 17));

    for (int k = 0; k < 8; k++) begin
      if (!hpend) raise_host(1'b0, 16'hC000 + 16'(2 * k), 16'h0000);
      instr(1'b1, 16'(2 * k), 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    end
    if (hpend) gap();

    instr(1'b1, 16'h0020, 1'b1, 1'b1, 1'b0, 16'h0200, 16'h7700);
    bus.ioe = 1'b1;
    bus.iaddr = 16'h0006;
    bus.doe = 1'b0;
    bus.dwe0 = 1'b1;
    bus.dwe1 = 1'b1;
    bus.daddr = 16'hC004;
    bus.ddout = 16'h5A5A;
    e = base();
    e.stall = 1'b1;
    e.en = 1'b1;
    e.we = 2'b11;
    e.ma = 15'h6002;
    e.wd = 16'h5A5A;
    ref_mem[15'h6002] = 16'h5A5A;
    cycle(e);
    rst = 1'b1;
    e = base();
    e.chk = 1'b0;
    e.rs = 1'b1;
    cycle(e);
    rst = 1'b0;
    id_m = '0;
    dd_m = '0;
    led_m = '0;
    hturn = 1'b0;
    gap();
    chk("led_after_rst", led, 24'h000000);
    chk("store_before_rst", sram[15'h6002], 16'h5A5A);

    for (int n = 0; n < 400; n++) begin
      bit ioe;
      int kind;
      logic [1:0] w;
      logic [15:0] da;
      if (!hpend && $urandom_range(0, 9) < 3)
        raise_host(1'($urandom_range(0, 1)), 16'hC000 + 16'($urandom_range(0, 31)), 16'($urandom));
      if ($urandom_range(0, 5) == 0) gap();
      else begin
        ioe = $urandom_range(0, 3) != 0;
        kind = $urandom_range(0, 2);
        w = 2'($urandom_range(1, 3));
        da = ($urandom_range(0, 3) == 0) ? 16'h0200 + 16'($urandom_range(0, 3))
                                         : 16'hC000 + 16'($urandom_range(0, 31));
        if (!ioe && kind == 0) ioe = 1'b1;
        instr(ioe, 16'($urandom_range(0, 63)), kind == 1, kind == 2 && w[1], kind == 2 && w[0],
              da, 16'($urandom));
      end
    end
    if (hpend) gap();
    gap();

    for (int i = 0; i < 32; i++) chk("mem_code", sram[15'(i)], ref_mem[15'(i)]);
    for (int i = 0; i < 16; i++) chk("mem_data", sram[15'h6000 + 15'(i)], ref_mem[15'h6000 + 15'(i)]);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
